// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// The master side drives requests and hold; the slave side is the arbiter.
interface rf_wb_arbiter_if #(
  parameter int NR_REQ     = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int GID_W      = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
);
  logic                         hold;
  logic [NR_REQ-1:0]            req_valid;
  logic [NR_REQ-1:0]            req_ready;
  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NR_REQ*DATA_WIDTH-1:0] req_data;
  logic                         rf_wen;
  logic [ADDR_WIDTH-1:0]        rf_waddr;
  logic [DATA_WIDTH-1:0]        rf_wdata;
  logic [GID_W-1:0]             grant_id;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, grant_id
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, rf_wen, rf_waddr, rf_wdata, grant_id
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NR_REQ
// writeback requesters; the granted write is registered and presented one cycle later.
module rf_wb_arbiter #(
  parameter int NR_REQ      = 3,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int GID_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [GID_W-1:0]      ptr_q, ptr_d;
  logic [GID_W-1:0]      gid_q, gid_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  win_found;
  logic [GID_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  fire;
  logic [NR_REQ-1:0]     ready;
  int                    scan_idx;

  // Scan from ptr upward, wrapping at NR_REQ-1; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    win_data  = '0;
    scan_idx  = 0;
    for (int k = 0; k < NR_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NR_REQ) begin
        scan_idx = scan_idx - NR_REQ;
      end
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = GID_W'(scan_idx);
        win_addr  = bus.req_addr[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
        win_data  = bus.req_data[scan_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fire = win_found & ~bus.hold & ~rst;

  always_comb begin
    ready = '0;
    if (fire) begin
      ready[win_idx] = 1'b1;
    end
  end

  // Reset is synchronous, so it is folded into the next-state logic.
  always_comb begin
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (rst) begin
      ptr_d   = '0;
      gid_d   = '0;
      waddr_d = '0;
      wdata_d = '0;
    end else if (fire) begin
      wen_d   = !(ZERO_REG_RO && (win_addr == '0));
      waddr_d = win_addr;
      wdata_d = win_data;
      gid_d   = win_idx;
      ptr_d   = (win_idx == GID_W'(NR_REQ - 1)) ? '0 : win_idx + GID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    ptr_q   <= ptr_d;
    gid_q   <= gid_d;
    wen_q   <= wen_d;
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
  end

  assign bus.req_ready = ready;
  assign bus.rf_wen    = wen_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.grant_id  = gid_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table for the corner cases, then
// randomized requesters checked against a round-robin reference model.
module tb_rf_wb_arbiter;

  localparam int NR_REQ = 3;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int GW     = 2;

  localparam logic [NR_REQ*AW-1:0] ADDR_STD = {5'd7, 5'd5, 5'd3};
  localparam logic [NR_REQ*DW-1:0] DATA_STD = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1000_0000};
  localparam logic [NR_REQ*AW-1:0] ADDR_X0  = {5'd0, 5'd5, 5'd3};
  localparam logic [NR_REQ*DW-1:0] DATA_X0  = {32'h0000_1234, 32'hDEAD_BEEF, 32'h1000_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NR_REQ(NR_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GID_W(GW)) bus ();

  rf_wb_arbiter #(
    .NR_REQ(NR_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG_RO(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic                 rst;
    logic                 hold;
    logic [NR_REQ-1:0]    valid;
    logic [NR_REQ*AW-1:0] addr;
    logic [NR_REQ*DW-1:0] data;
    logic [NR_REQ-1:0]    exp_ready;
    logic                 exp_wen;
    logic [AW-1:0]        exp_waddr;
    logic [DW-1:0]        exp_wdata;
    logic [GW-1:0]        exp_gid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic h, input logic [NR_REQ-1:0] v,
                              input logic [NR_REQ*AW-1:0] a, input logic [NR_REQ*DW-1:0] d,
                              input logic [NR_REQ-1:0] er, input logic ew, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ed, input logic [GW-1:0] eg);
    vec_t t;
    t.rst = r; t.hold = h; t.valid = v; t.addr = a; t.data = d;
    t.exp_ready = er; t.exp_wen = ew; t.exp_waddr = ea; t.exp_wdata = ed; t.exp_gid = eg;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge and settle for 1 time unit before checks.
  task automatic applyStimulus(input logic r, input logic h, input logic [NR_REQ-1:0] v,
                               input logic [NR_REQ*AW-1:0] a, input logic [NR_REQ*DW-1:0] d);
    @(negedge clk);
    rst           = r;
    bus.hold      = h;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int            m_ptr;
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_gid;
  bit            p_valid[NR_REQ];
  logic [AW-1:0] p_addr[NR_REQ];
  logic [DW-1:0] p_data[NR_REQ];

  initial begin
    logic [NR_REQ-1:0]    v;
    logic [NR_REQ*AW-1:0] a;
    logic [NR_REQ*DW-1:0] d;
    logic [NR_REQ-1:0]    exp_ready;
    logic                 r, h;
    int                   win;
    int                   idx;

    // Directed rows: reset, single requester, rotation, hold, reset mid-stream, x0 write.
    vecs.push_back(mk(1, 0, 3'b111, ADDR_STD, DATA_STD, 3'b000, 0, 5'd0, 32'h0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b111, ADDR_STD, DATA_STD, 3'b000, 0, 5'd0, 32'h0, 2'd0));
    vecs.push_back(mk(0, 0, 3'b010, ADDR_STD, DATA_STD, 3'b010, 1, 5'd5, 32'hDEAD_BEEF, 2'd1));
    vecs.push_back(mk(1, 0, 3'b111, ADDR_STD, DATA_STD, 3'b000, 0, 5'd0, 32'h0, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b001, 1, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b010, 1, 5'd5, 32'hDEAD_BEEF, 2'd1));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b100, 1, 5'd7, 32'h2222_2222, 2'd2));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b001, 1, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b010, 1, 5'd5, 32'hDEAD_BEEF, 2'd1));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b100, 1, 5'd7, 32'h2222_2222, 2'd2));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b001, 1, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 1, 3'b111, ADDR_STD, DATA_STD, 3'b000, 0, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 1, 3'b111, ADDR_STD, DATA_STD, 3'b000, 0, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 1, 3'b111, ADDR_STD, DATA_STD, 3'b000, 0, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b010, 1, 5'd5, 32'hDEAD_BEEF, 2'd1));
    vecs.push_back(mk(1, 0, 3'b111, ADDR_STD, DATA_STD, 3'b000, 0, 5'd0, 32'h0, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, ADDR_STD, DATA_STD, 3'b001, 1, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 0, 3'b100, ADDR_X0,  DATA_X0,  3'b100, 0, 5'd0, 32'h0000_1234, 2'd2));
    vecs.push_back(mk(0, 0, 3'b000, ADDR_X0,  DATA_X0,  3'b000, 0, 5'd0, 32'h0000_1234, 2'd2));
    vecs.push_back(mk(0, 0, 3'b101, ADDR_STD, DATA_STD, 3'b001, 1, 5'd3, 32'h1000_0000, 2'd0));
    vecs.push_back(mk(0, 0, 3'b101, ADDR_STD, DATA_STD, 3'b100, 1, 5'd7, 32'h2222_2222, 2'd2));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].hold, vecs[i].valid, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
      tick();
      checkOutput($sformatf("vec%0d rf_wen", i), 64'(bus.rf_wen), 64'(vecs[i].exp_wen));
      checkOutput($sformatf("vec%0d rf_waddr", i), 64'(bus.rf_waddr), 64'(vecs[i].exp_waddr));
      checkOutput($sformatf("vec%0d rf_wdata", i), 64'(bus.rf_wdata), 64'(vecs[i].exp_wdata));
      checkOutput($sformatf("vec%0d grant_id", i), 64'(bus.grant_id), 64'(vecs[i].exp_gid));
    end

    // Randomized phase: start from a known reset state.
    applyStimulus(1, 0, '0, '0, '0);
    tick();
    m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_gid = 0;
    for (int j = 0; j < NR_REQ; j++) p_valid[j] = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int j = 0; j < NR_REQ; j++) begin
        if (!p_valid[j] && ($urandom_range(0, 1) == 1)) begin
          p_valid[j] = 1;
          p_addr[j]  = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
          p_data[j]  = $urandom;
        end
      end
      r = ($urandom_range(0, 39) == 0);
      h = ($urandom_range(0, 4) == 0);
      for (int j = 0; j < NR_REQ; j++) begin
        v[j]          = p_valid[j];
        a[j*AW +: AW] = p_addr[j];
        d[j*DW +: DW] = p_data[j];
      end
      applyStimulus(r, h, v, a, d);

      win = -1;
      if (!r && !h) begin
        for (int k = 0; k < NR_REQ; k++) begin
          idx = (m_ptr + k) % NR_REQ;
          if (win < 0 && p_valid[idx]) win = idx;
        end
      end
      exp_ready = (win >= 0) ? NR_REQ'(1 << win) : '0;
      checkOutput($sformatf("rnd%0d ready", cyc), 64'(bus.req_ready), 64'(exp_ready));
      tick();

      if (r) begin
        m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_gid = 0;
      end else if (win >= 0) begin
        m_wen      = (p_addr[win] != 0);
        m_waddr    = p_addr[win];
        m_wdata    = p_data[win];
        m_gid      = win;
        m_ptr      = (win + 1) % NR_REQ;
        p_valid[win] = 0;
      end else begin
        m_wen = 0;
      end
      checkOutput($sformatf("rnd%0d rf_wen", cyc), 64'(bus.rf_wen), 64'(m_wen));
      checkOutput($sformatf("rnd%0d rf_waddr", cyc), 64'(bus.rf_waddr), 64'(m_waddr));
      checkOutput($sformatf("rnd%0d rf_wdata", cyc), 64'(bus.rf_wdata), 64'(m_wdata));
      checkOutput($sformatf("rnd%0d grant_id", cyc), 64'(bus.grant_id), 64'(m_gid));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
